im_loader: RTL and testbench

- Write-side counterpart to the PC/instruction-memory fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles 24-bit instructions from three bytes, MSB first.
- Writes each instruction into instruction memory at consecutive 8-bit addresses.
- Holds the fetch pipeline stalled while loading, then pulses done so the core can be released from reset at the loaded program.

---
 rtl/im_loader.sv | 141 ++++++++++++++
 tb/tb_im_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// rtl/im_loader.sv - assembles a byte stream into 24-bit instructions and writes them to instruction memory
// IM_LOADER_CHKSUM_EN adds a trailing XOR checksum byte and drives chk_err.
module im_loader #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [INS_W-1:0]  im_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              chk_err
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IM_LOADER_CHKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t     state;
  logic [1:0] bcnt;
  logic [7:0] icnt;
  logic [7:0] len_q;
  logic       accept;
`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0] chk_acc;
`else
  assign chk_err = 1'b0;
`endif

  assign accept = byte_valid & byte_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bcnt       <= 2'd0;
      icnt       <= 8'd0;
      len_q      <= 8'd0;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_waddr   <= '0;
      im_wdata   <= '0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
`ifdef IM_LOADER_CHKSUM_EN
      chk_acc    <= 8'd0;
      chk_err    <= 1'b0;
`endif
    end else begin
      im_we     <= 1'b0;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            im_waddr <= base_addr;
            len_q    <= len;
            bcnt     <= 2'd0;
            icnt     <= 8'd0;
`ifdef IM_LOADER_CHKSUM_EN
            chk_acc  <= 8'd0;
            chk_err  <= 1'b0;
`endif
            if (len != 8'd0) begin
              state      <= RECV;
              byte_ready <= 1'b1;
              load_busy  <= 1'b1;
            end else begin
              state     <= DONE;
              load_done <= 1'b1;
            end
          end
        end
        RECV: begin
          if (accept) begin
            // MSB-first: the byte slot follows the position within the instruction
            case (bcnt)
              2'd0:    im_wdata[INS_W-1 -: 8] <= byte_in;
              2'd1:    im_wdata[INS_W-9 -: 8] <= byte_in;
              default: im_wdata[7:0]          <= byte_in;
            endcase
`ifdef IM_LOADER_CHKSUM_EN
            chk_acc <= chk_acc ^ byte_in;
`endif
            if (bcnt == 2'd2) begin
              bcnt       <= 2'd0;
              state      <= WRITE;
              byte_ready <= 1'b0;
              im_we      <= 1'b1;
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end
        end
        WRITE: begin
          if (icnt == len_q - 8'd1) begin
`ifdef IM_LOADER_CHKSUM_EN
            state      <= CHK;
            byte_ready <= 1'b1;
`else
            state     <= DONE;
            load_busy <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            icnt       <= icnt + 8'd1;
            im_waddr   <= im_waddr + ADDR_W'(1);
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
`ifdef IM_LOADER_CHKSUM_EN
        CHK: begin
          if (accept) begin
            chk_err    <= (byte_in != chk_acc);
            byte_ready <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b1;
            state      <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - randomized and directed self-checking bench for im_loader
module tb_im_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  len;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [23:0] im_wdata;
  logic        load_busy;
  logic        load_done;
  logic        chk_err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] pat[$];

  im_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {27'd0, byte_ready, im_we, load_busy, load_done, chk_err, im_waddr, im_wdata};
  endfunction

  // One load: the model lists the writes implied by base/len/stream, the loop drives and observes.
  task automatic run_load(input logic [7:0] base, input logic [7:0] n, input int gap_pct,
                          input bit bad_chk, input int restart_at, input string tag);
    logic [7:0]  s[$];
    logic [7:0]  x;
    logic [31:0] obs_w[$];
    logic        exp_err;
    logic        chk_obs;
    int idx, c, dones, extra_we, busy_bad, rdy_bad, first_we, done_c;
    bit pv, pr, fin;
    s = {};
    x = 8'd0;
    for (int i = 0; i < 3 * n; i++) begin
      s.push_back((i < pat.size()) ? pat[i] : 8'($urandom));
      x ^= s[i];
    end
    pat = {};
    exp_err = 1'b0;
`ifdef IM_LOADER_CHKSUM_EN
    if (n != 8'd0) begin
      s.push_back(bad_chk ? (x ^ 8'($urandom_range(1, 255))) : x);
      exp_err = bad_chk;
    end
`endif
    idx = 0; c = 0; dones = 0; extra_we = 0; busy_bad = 0; rdy_bad = 0;
    first_we = -1; done_c = -1; fin = 0; chk_obs = 1'bx;
    obs_w = {};
    @(negedge clk);
    start = 1'b1; base_addr = base; len = n;
    byte_valid = 1'b1;
    byte_in = (s.size() != 0) ? s[0] : 8'($urandom);
    pv = 1'b1; pr = byte_ready;
    while (!fin && c < 300) begin
      @(negedge clk);
      c++;
      if (c == restart_at) begin
        start = 1'b1; base_addr = base + 8'h40; len = 8'd7;
      end else begin
        start = 1'b0;
      end
      if (pv && pr) idx++;
      if (im_we) begin
        obs_w.push_back({im_waddr, im_wdata});
        if (first_we < 0) first_we = c;
        if (byte_ready) rdy_bad++;
      end
      if (load_done) begin
        dones++; fin = 1; done_c = c; chk_obs = chk_err;
        if (load_busy) busy_bad++;
      end else if (load_busy !== (n != 8'd0)) begin
        busy_bad++;
      end
      if (idx < s.size()) begin
        if (gap_pct < 0)       byte_valid = c[0];
        else if (gap_pct == 0) byte_valid = 1'b1;
        else                   byte_valid = ($urandom_range(0, 99) >= gap_pct);
        byte_in = s[idx];
      end else begin
        byte_valid = 1'b1;
        byte_in = 8'($urandom);
      end
      pv = byte_valid; pr = byte_ready;
    end
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
      if (pv && pr) idx++;
      pv = 1'b0;
      byte_valid = 1'b0;
      if (load_done) dones++;
      if (im_we) extra_we++;
    end
    check({tag, " finished"}, 64'(fin), 64'd1);
    check({tag, " done pulses"}, 64'(dones), 64'd1);
    check({tag, " write count"}, 64'(obs_w.size() + extra_we), 64'(n));
    for (int i = 0; i < obs_w.size() && i < n; i++)
      check({tag, " write addr/data"}, 64'(obs_w[i]),
            64'({8'(base + 8'(i)), s[3*i], s[3*i+1], s[3*i+2]}));
    check({tag, " bytes consumed"}, 64'(idx), 64'(s.size()));
    check({tag, " busy profile"}, 64'(busy_bad), 64'd0);
    check({tag, " ready during write"}, 64'(rdy_bad), 64'd0);
    check({tag, " chk_err"}, 64'(chk_obs), 64'(exp_err));
    if (gap_pct == 0 && n != 8'd0) check({tag, " first write latency"}, 64'(first_we), 64'd4);
    if (n == 8'd0) check({tag, " done latency"}, 64'(done_c), 64'd1);
  endtask

  initial begin
    int bad;
    clk = 1'b0; reset = 1'b0; start = 1'b0; base_addr = 8'h00; len = 8'h00;
    byte_in = 8'h00; byte_valid = 1'b0;
    #1 check("reset outputs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    bad = 0;
    repeat (10) begin
      @(negedge clk);
      byte_valid = 1'b1; byte_in = 8'($urandom);
      if (all_outs() !== 64'd0) bad++;
    end
    check("idle outputs quiet", 64'(bad), 64'd0);
    byte_valid = 1'b0;

    pat = '{8'h12, 8'h34, 8'h56, 8'h9A, 8'hBC, 8'hDE};
    run_load(8'h08, 8'd2, 0, 1'b0, -1, "basic");
    pat = '{8'h01, 8'h02, 8'h03};
    run_load(8'h20, 8'd1, -1, 1'b0, -1, "toggle");
    run_load(8'hFF, 8'd2, 30, 1'b0, -1, "wrap");
    run_load(8'h50, 8'd0, 0, 1'b0, -1, "len0");
    run_load(8'h60, 8'd3, 0, 1'b0, 5, "restart ignored");

    @(negedge clk);
    start = 1'b1; base_addr = 8'h30; len = 8'd1;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'h11;
    @(negedge clk);
    byte_in = 8'h22;
    @(negedge clk);
    byte_valid = 1'b0;
    reset = 1'b0;
    #1 check("async reset mid-load", all_outs(), 64'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (im_we || load_done) bad++;
    end
    check("no write/done under reset", 64'(bad), 64'd0);
    reset = 1'b1;
    pat = '{8'hAA, 8'hBB, 8'hCC};
    run_load(8'h30, 8'd1, 0, 1'b1, -1, "after reset bad chk");
    pat = '{8'hAA, 8'hBB, 8'hCC};
    run_load(8'h30, 8'd1, 0, 1'b0, -1, "after reset good chk");

    for (int k = 0; k < 8; k++)
      run_load(8'($urandom), 8'($urandom_range(1, 5)), int'($urandom_range(0, 60)),
               1'($urandom), -1, "random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
